// File: rtl/rr_grant_scheduler_if.sv
// ---------------------------------------------------------------------------
// rr_grant_scheduler_if
//   Request/grant bundle between WIDTH requesters (plus the shared resource's
//   done strobe) and the round-robin grant scheduler.
//
//   req       requester -> scheduler  level request per requester
//   done      resource  -> scheduler  one-cycle transaction-complete pulse
//   gnt       scheduler -> requesters one-hot grant, zero when idle
//   gnt_valid scheduler -> requesters |gnt
//   gnt_id    scheduler -> requesters binary index of the granted requester
//   timeout   scheduler -> requesters pulse on a hold-limit forced release
//   busy      scheduler -> requesters high while a grant is held
//
//   master: the requester/resource side; slave: the scheduler.
// ---------------------------------------------------------------------------
interface rr_grant_scheduler_if #(
   parameter int WIDTH = 8
);
   localparam int IDW = $clog2(WIDTH);

   logic [WIDTH-1:0] req;
   logic             done;
   logic [WIDTH-1:0] gnt;
   logic             gnt_valid;
   logic [IDW-1:0]   gnt_id;
   logic             timeout;
   logic             busy;

   modport master (
      output req, done,
      input  gnt, gnt_valid, gnt_id, timeout, busy
   );

   modport slave (
      input  req, done,
      output gnt, gnt_valid, gnt_id, timeout, busy
   );
endinterface

// File: rtl/rr_grant_scheduler.sv
// ---------------------------------------------------------------------------
// rr_grant_scheduler
//   Round-robin owner of one downstream resource shared by WIDTH requesters.
//   Priority rotates via a thermometer mask (prefix-OR of the last winner's
//   one-hot), so the requester just above the previous winner is preferred;
//   with no masked request the lowest raw request wins (wrap-around).
//   A grant is held until done, the owner drops req, or MAX_HOLD cycles
//   elapse (MAX_HOLD = 0 disables the limit). Every release passes through
//   one idle cycle before the next arbitration.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    rr_grant_scheduler_if.slave (req, done in; gnt, gnt_valid,
//            gnt_id, timeout, busy out - all outputs registered)
// ---------------------------------------------------------------------------

// Per-lane slice: one bit of the thermometer mask plus one stage of the two
// lowest-set-bit find chains (masked and raw request vectors).
module rr_grant_lane (
   input  logic req_i,        // this lane's request
   input  logic last_prev_i,  // last_oh of the lane below
   input  logic mask_prev_i,  // mask of the lane below
   input  logic mfound_i,     // some lower lane already has a masked request
   input  logic ufound_i,     // some lower lane already has a raw request
   output logic mask_o,
   output logic win_m_o,
   output logic win_u_o,
   output logic mfound_o,
   output logic ufound_o
);
   logic masked;

   assign mask_o   = last_prev_i | mask_prev_i;
   assign masked   = req_i & mask_o;
   assign win_m_o  = masked & ~mfound_i;
   assign mfound_o = mfound_i | masked;
   assign win_u_o  = req_i & ~ufound_i;
   assign ufound_o = ufound_i | req_i;
endmodule

module rr_grant_scheduler #(
   parameter int WIDTH    = 8,
   parameter int MAX_HOLD = 16
) (
   input logic               clk,
   input logic               rst_n,
   rr_grant_scheduler_if.slave bus
);
   localparam int IDW = $clog2(WIDTH);
   localparam int CW  = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_MAX_C = CW'(MAX_HOLD);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] gnt_q, gnt_d;
   logic [WIDTH-1:0] last_oh_q, last_oh_d;
   logic [IDW-1:0]   gnt_id_q, gnt_id_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic             busy_q, busy_d;
   logic             timeout_q, timeout_d;
   logic [CW-1:0]    hold_cnt_q, hold_cnt_d;

   // -------------------------------------------------------------------------
   // Arbitration datapath
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] win_m, win_u;
   logic [WIDTH:0]   mfound, ufound;
   logic [WIDTH-1:0] winner;
   logic [IDW-1:0]   win_id;

   assign mfound[0] = 1'b0;
   assign ufound[0] = 1'b0;

   for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      logic last_prev, mask_prev;
      if (i == 0) begin : g_first
         assign last_prev = 1'b0;
         assign mask_prev = 1'b0;
      end else begin : g_rest
         assign last_prev = last_oh_q[i-1];
         assign mask_prev = mask[i-1];
      end

      rr_grant_lane u_lane (
         .req_i       (bus.req[i]),
         .last_prev_i (last_prev),
         .mask_prev_i (mask_prev),
         .mfound_i    (mfound[i]),
         .ufound_i    (ufound[i]),
         .mask_o      (mask[i]),
         .win_m_o     (win_m[i]),
         .win_u_o     (win_u[i]),
         .mfound_o    (mfound[i+1]),
         .ufound_o    (ufound[i+1])
      );
   end

   // End of each find chain doubles as the "any request" reduction.
   logic any_masked, any_req;
   assign any_masked = mfound[WIDTH];
   assign any_req    = ufound[WIDTH];
   assign winner     = any_masked ? win_m : win_u;

   always_comb begin
      win_id = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (winner[i]) win_id = win_id | IDW'(i);
      end
   end

   // -------------------------------------------------------------------------
   // Release causes while a grant is held
   // -------------------------------------------------------------------------
   logic owner_drop, hit_limit, release_now;

   assign owner_drop  = ~|(bus.req & gnt_q);
   assign hit_limit   = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_MAX_C);
   assign release_now = bus.done | owner_drop | hit_limit;

   // -------------------------------------------------------------------------
   // FSM next-state / outputs
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      gnt_id_d    = gnt_id_q;
      gnt_valid_d = gnt_valid_q;
      busy_d      = busy_q;
      timeout_d   = 1'b0;
      hold_cnt_d  = hold_cnt_q;
      last_oh_d   = last_oh_q;

      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d     = GRANT;
               gnt_d       = winner;
               gnt_id_d    = win_id;
               gnt_valid_d = 1'b1;
               busy_d      = 1'b1;
               hold_cnt_d  = CW'(1);
               last_oh_d   = winner;
            end
         end
         GRANT: begin
            if (release_now) begin
               state_d     = IDLE;
               gnt_d       = '0;
               gnt_id_d    = '0;
               gnt_valid_d = 1'b0;
               busy_d      = 1'b0;
               hold_cnt_d  = '0;
               // Flag only releases forced purely by the hold limit.
               timeout_d   = hit_limit & ~bus.done & ~owner_drop;
            end else if ((MAX_HOLD != 0) && (hold_cnt_q != HOLD_MAX_C)) begin
               hold_cnt_d = hold_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // -------------------------------------------------------------------------
   // State register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         gnt_q       <= '0;
         gnt_id_q    <= '0;
         gnt_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         hold_cnt_q  <= '0;
         // Last winner = top bit, so the first arbitration favours bit 0.
         last_oh_q   <= {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         gnt_id_q    <= gnt_id_d;
         gnt_valid_q <= gnt_valid_d;
         busy_q      <= busy_d;
         timeout_q   <= timeout_d;
         hold_cnt_q  <= hold_cnt_d;
         last_oh_q   <= last_oh_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.gnt_id    = gnt_id_q;
   assign bus.gnt_valid = gnt_valid_q;
   assign bus.busy      = busy_q;
   assign bus.timeout   = timeout_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
// Bench for rr_grant_scheduler: two builds (WIDTH=4, MAX_HOLD=4 and 0) fed
// the same stimulus, each tracked by an owner/rotation reference model.
module tb_rr_grant_scheduler;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = '0;
   logic       done = 1'b0;
   bit         chk_en = 1'b0;
   int         checks = 0;
   int         failures = 0;

   always #5 clk = ~clk;

   rr_grant_scheduler_if #(.WIDTH(4)) bus0 ();
   rr_grant_scheduler_if #(.WIDTH(4)) bus1 ();

   assign bus0.req  = req;
   assign bus0.done = done;
   assign bus1.req  = req;
   assign bus1.done = done;

   rr_grant_scheduler #(.WIDTH(4), .MAX_HOLD(4)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
   rr_grant_scheduler #(.WIDTH(4), .MAX_HOLD(0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

   // Reference model: who owns the resource, for how long, and who won last.
   typedef struct packed {
      int owner;   // -1 when idle
      int cnt;     // cycles the current grant has been visible
      int last;    // index of the last winner
      bit to;      // timeout pulse expected this cycle
   } m_t;

   m_t m0, m1;

   function automatic m_t m_reset();
      m_t s;
      s.owner = -1; s.cnt = 0; s.last = 3; s.to = 1'b0;
      return s;
   endfunction

   function automatic m_t step(m_t s, logic [3:0] r, logic d, int mh);
      m_t n = s;
      n.to = 1'b0;
      if (s.owner < 0) begin
         // Search upward from the last winner, wrapping around.
         for (int k = 1; k <= 4; k++) begin
            int c = (s.last + k) % 4;
            if (r[c] && n.owner < 0) begin
               n.owner = c; n.last = c; n.cnt = 1;
            end
         end
      end else begin
         bit drop = !r[s.owner];
         bit lim  = (mh != 0) && (s.cnt == mh);
         if (d || drop || lim) begin
            n.owner = -1; n.cnt = 0;
            n.to = lim && !d && !drop;
         end else begin
            n.cnt = s.cnt + 1;
         end
      end
      return n;
   endfunction

   function automatic int e_gnt(m_t s);   return (s.owner < 0) ? 0 : (1 << s.owner); endfunction
   function automatic int e_id(m_t s);    return (s.owner < 0) ? 0 : s.owner;        endfunction
   function automatic int e_vld(m_t s);   return (s.owner < 0) ? 0 : 1;              endfunction

   task automatic cmp(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   // Every cycle: both DUTs against their models, sampled mid-cycle.
   always @(negedge clk) begin
      if (chk_en) begin
         cmp("gnt0",   int'(bus0.gnt),       e_gnt(m0));
         cmp("id0",    int'(bus0.gnt_id),    e_id(m0));
         cmp("vld0",   int'(bus0.gnt_valid), e_vld(m0));
         cmp("busy0",  int'(bus0.busy),      e_vld(m0));
         cmp("to0",    int'(bus0.timeout),   int'(m0.to));
         cmp("gnt1",   int'(bus1.gnt),       e_gnt(m1));
         cmp("id1",    int'(bus1.gnt_id),    e_id(m1));
         cmp("vld1",   int'(bus1.gnt_valid), e_vld(m1));
         cmp("busy1",  int'(bus1.busy),      e_vld(m1));
         cmp("to1",    int'(bus1.timeout),   int'(m1.to));
      end
   end

   // One clock: advance models with the inputs seen at the edge, then move
   // 1 time unit past the edge so callers can read and redrive safely.
   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m0 = m_reset(); m1 = m_reset();
      end else begin
         m0 = step(m0, req, done, 4);
         m1 = step(m1, req, done, 0);
      end
      #1;
   endtask

   task automatic wait_grant(input int maxc);
      int n = 0;
      while (!bus0.gnt_valid && n < maxc) begin
         tick();
         n++;
      end
      if (!bus0.gnt_valid) begin
         checks++; failures++;
         $display("FAIL wait_grant actual=idle expected=grant");
      end
   endtask

   initial begin
      int exp_seq[5] = '{1, 2, 4, 8, 1};
      m0 = m_reset(); m1 = m_reset();
      tick(); tick();
      chk_en = 1'b1;
      tick();
      rst_n = 1'b1;

      // Reset state
      cmp("rst_gnt",  int'(bus0.gnt), 0);
      cmp("rst_vld",  int'(bus0.gnt_valid), 0);
      cmp("rst_id",   int'(bus0.gnt_id), 0);
      cmp("rst_busy", int'(bus0.busy), 0);
      cmp("rst_to",   int'(bus0.timeout), 0);

      // Full rotation with done two cycles after each grant
      req = 4'b1111;
      tick();
      wait_grant(8);
      foreach (exp_seq[i]) begin
         cmp("rot_gnt", int'(bus0.gnt), exp_seq[i]);
         tick();
         done = 1'b1;
         tick();
         done = 1'b0;
         cmp("rot_idle", int'(bus0.gnt), 0);
         tick();
      end
      cmp("rot_next", int'(bus0.gnt), 4'b0010);

      // Release 0010, only requester 0 left: wrap-around
      done = 1'b1; req = 4'b0001;
      tick();
      done = 1'b0;
      tick();
      cmp("wrap_gnt", int'(bus0.gnt), 4'b0001);
      cmp("wrap_id",  int'(bus0.gnt_id), 0);

      // Hold limit: 4 visible cycles, timeout pulse, regrant
      req = 4'b0100;
      tick(); tick();
      cmp("hold_gnt", int'(bus0.gnt), 4'b0100);
      for (int i = 0; i < 3; i++) begin
         tick();
         cmp("hold_keep", int'(bus0.gnt), 4'b0100);
      end
      tick();
      cmp("to_gnt",   int'(bus0.gnt), 0);
      cmp("to_pulse", int'(bus0.timeout), 1);
      tick();
      cmp("to_regnt", int'(bus0.gnt), 4'b0100);
      cmp("to_clr",   int'(bus0.timeout), 0);

      // Owner drop with others waiting
      req = 4'b1000;
      tick(); tick();
      cmp("own_gnt", int'(bus0.gnt), 4'b1000);
      req = 4'b0110;
      tick();
      cmp("drop_gnt", int'(bus0.gnt), 0);
      cmp("drop_to",  int'(bus0.timeout), 0);
      tick();
      cmp("drop_next", int'(bus0.gnt), 4'b0010);
      cmp("drop_id",   int'(bus0.gnt_id), 1);

      // done coincides with the hold limit
      tick(); tick(); tick();
      cmp("coin_gnt", int'(bus0.gnt), 4'b0010);
      done = 1'b1;
      tick();
      done = 1'b0;
      cmp("coin_rel", int'(bus0.gnt), 0);
      cmp("coin_to",  int'(bus0.timeout), 0);

      // MAX_HOLD=0 build never times out
      req = 4'b0000;
      tick(); tick();
      req = 4'b0001;
      tick();
      for (int i = 0; i < 100; i++) begin
         tick();
         cmp("nolim_gnt", int'(bus1.gnt), 4'b0001);
      end

      // Asynchronous reset mid-grant
      req = 4'b0100;
      begin
         int n = 0;
         while (bus0.gnt != 4'b0100 && n < 10) begin tick(); n++; end
         cmp("arst_pre", int'(bus0.gnt), 4'b0100);
      end
      rst_n = 1'b0;
      m0 = m_reset(); m1 = m_reset();
      #1;
      cmp("arst_gnt0", int'(bus0.gnt), 0);
      cmp("arst_gnt1", int'(bus1.gnt), 0);
      tick(); tick();
      rst_n = 1'b1;
      req = 4'b1111;
      tick();
      cmp("arst_first", int'(bus0.gnt), 4'b0001);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
         done = ($urandom_range(0, 5) == 0);
         tick();
      end
      done = 1'b0;
      tick();

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
